// File: rtl/alu_4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_4_pkg
// Description : Shared opcode type and named opcode constants for the alu_4
//               block and its combinational core.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_4_pkg;

  // 3-bit opcode; every encoding is a legal operation
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_CMP = 3'b111
  } alu_op_t;

endpackage : alu_4_pkg
`default_nettype wire

// File: rtl/alu_4_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_4_core
// Description : Purely combinational ALU datapath. Produces a WIDTH-bit result
//               and a carry/borrow/shifted-out bit from A, B and the opcode.
//               WIDTH must be at least 3 so the three CMP flags fit.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_4_core
  import alu_4_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALU_Sel,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  alu_op_t op;
  assign op = alu_op_t'(ALU_Sel);

  // Decode the opcode into a result/carry pair; defaults keep this latch-free
  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: {carry, result} = {1'b0, A} + {1'b0, B};
      OP_SUB: begin
        result = A - B;
        carry  = (A < B);      // borrow out of the subtraction
      end
      OP_AND: result = A & B;
      OP_OR:  result = A | B;
      OP_XOR: result = A ^ B;
      OP_SHL: begin
        result = {A[WIDTH-2:0], 1'b0};
        carry  = A[WIDTH-1];
      end
      OP_SHR: begin
        result = {1'b0, A[WIDTH-1:1]};
        carry  = A[0];
      end
      OP_CMP: begin
        // one-hot flags: bit0 equal, bit1 greater, bit2 less
        result[0] = (A == B);
        result[1] = (A > B);
        result[2] = (A < B);
      end
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

endmodule : alu_4_core
`default_nettype wire

// File: rtl/alu_4.sv
`default_nettype none
// ============================================================================
// Module      : alu_4
// Description : Registered ALU wrapper. One-cycle latency from in_valid to
//               out_valid; results hold while in_valid is low. The optional
//               Zero output is enabled by defining ALU_4_ZERO_FLAG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_4
  import alu_4_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALU_Sel,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             Carry_Out,
  output logic             out_valid
`ifdef ALU_4_ZERO_FLAG_EN
  ,
  output logic             Zero
`endif
);

  logic [WIDTH-1:0] core_result;
  logic             core_carry;

  alu_4_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .A       (A),
    .B       (B),
    .ALU_Sel (ALU_Sel),
    .result  (core_result),
    .carry   (core_carry)
  );

  // Capture the core result on valid cycles; out_valid is a one-cycle echo
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALU_Out   <= '0;
      Carry_Out <= 1'b0;
      out_valid <= 1'b0;
`ifdef ALU_4_ZERO_FLAG_EN
      Zero      <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        ALU_Out   <= core_result;
        Carry_Out <= core_carry;
`ifdef ALU_4_ZERO_FLAG_EN
        Zero      <= (core_result == '0);
`endif
      end
    end
  end

endmodule : alu_4
`default_nettype wire

// File: tb/tb_alu_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_4
// Description : Self-checking bench for alu_4. A driver pushes expected
//               results into a queue; a monitor pops and compares whenever
//               out_valid is seen, and checks hold behaviour otherwise.
//               Define ALU_4_ZERO_FLAG_EN to also check the Zero output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_4;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  typedef struct {
    logic [W-1:0] out;
    logic         c;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   sel = '0;
  logic [W-1:0] alu_out;
  logic         carry_out;
  logic         out_valid;
`ifdef ALU_4_ZERO_FLAG_EN
  logic         zero;
`endif

  exp_t         q[$];
  exp_t         held = '{out: '0, c: 1'b0};
  int           n_checks = 0;
  int           n_fail = 0;

  alu_4 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (a),
    .B         (b),
    .ALU_Sel   (sel),
    .ALU_Out   (alu_out),
    .Carry_Out (carry_out),
    .out_valid (out_valid)
`ifdef ALU_4_ZERO_FLAG_EN
    ,
    .Zero      (zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model written directly from the opcode definitions
  function automatic exp_t model(input int av, input int bv, input int op);
    exp_t e;
    int   r;
    int   c;
    c = 0;
    case (op)
      0: begin r = av + bv; c = (r >= MOD) ? 1 : 0; r = r % MOD; end
      1: begin r = (av - bv + MOD) % MOD; c = (av < bv) ? 1 : 0; end
      2: r = av & bv;
      3: r = av | bv;
      4: r = av ^ bv;
      5: begin r = (av * 2) % MOD; c = (av >= MOD / 2) ? 1 : 0; end
      6: begin r = av / 2; c = av % 2; end
      default: r = (av == bv) ? 1 : ((av > bv) ? 2 : 4);
    endcase
    e.out = r[W-1:0];
    e.c   = c[0];
    return e;
  endfunction

  // Present one operation; it is sampled at the following rising edge
  task automatic issue(input int av, input int bv, input int op,
                       input int eo, input int ec);
    exp_t e;
    @(posedge clk);
    #2;
    in_valid = 1'b1;
    a   = av[W-1:0];
    b   = bv[W-1:0];
    sel = op[2:0];
    e.out = eo[W-1:0];
    e.c   = ec[0];
    q.push_back(e);
  endtask

  task automatic issue_model(input int av, input int bv, input int op);
    exp_t e;
    e = model(av, bv, op);
    issue(av, bv, op, int'(e.out), int'(e.c));
  endtask

  task automatic idle();
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_out"},   {28'd0, alu_out},   32'd0);
    check({tag, "_carry"}, {31'd0, carry_out}, 32'd0);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
`ifdef ALU_4_ZERO_FLAG_EN
    check({tag, "_zero"},  {31'd0, zero},      32'd0);
`endif
  endtask

  // Monitor: compare on out_valid, otherwise verify the outputs are held
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: out_valid=1 with no pending op at %0t", $time);
        end else begin
          e = q.pop_front();
          check("result", {28'd0, alu_out},   {28'd0, e.out});
          check("carry",  {31'd0, carry_out}, {31'd0, e.c});
`ifdef ALU_4_ZERO_FLAG_EN
          check("zero",   {31'd0, zero},      {31'd0, (e.out == '0)});
`endif
          held = e;
        end
      end else begin
        check("hold_result", {28'd0, alu_out},   {28'd0, held.out});
        check("hold_carry",  {31'd0, carry_out}, {31'd0, held.c});
`ifdef ALU_4_ZERO_FLAG_EN
        check("hold_zero",   {31'd0, zero},      {31'd0, (held.out == '0)});
`endif
      end
    end
  end

  // Driver
  initial begin
    int waited;
    #3;
    check_zero_outputs("reset");
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Opcode sweep with A=0101, B=0011 against fixed expected values
    issue(5, 3, 0, 4'b1000, 0);
    issue(5, 3, 1, 4'b0010, 0);
    issue(5, 3, 2, 4'b0001, 0);
    issue(5, 3, 3, 4'b0111, 0);
    issue(5, 3, 4, 4'b0110, 0);
    issue(5, 3, 5, 4'b1010, 0);
    issue(5, 3, 6, 4'b0010, 1);
    issue(5, 3, 7, 4'b0010, 0);

    // Wrap-around, compare, shift and zero-result corner cases
    issue(4'b1111, 4'b0001, 0, 4'b0000, 1);
    issue(4'b0011, 4'b0101, 1, 4'b1110, 1);
    issue(4'b0110, 4'b0110, 7, 4'b0001, 0);
    issue(4'b0010, 4'b1000, 7, 4'b0100, 0);
    issue(4'b1001, 4'b0000, 5, 4'b0010, 1);
    issue(4'b1000, 4'b0000, 6, 4'b0100, 0);
    issue(4'b1010, 4'b1010, 4, 4'b0000, 0);
    issue(4'b0001, 4'b0001, 0, 4'b0010, 0);

    // Three idle cycles: outputs must hold with out_valid low
    idle();
    idle();
    idle();
    idle();

    // Reset pulse mid-cycle after a valid op, with another op in flight
    issue(4'b0111, 4'b0100, 3, 4'b0111, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    q.delete();
    held = '{out: '0, c: 1'b0};
    a = 4'b1111;
    b = 4'b1111;
    sel = 3'b000;
    in_valid = 1'b1;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_zero_outputs("reset_discard");
    #2;
    rst_n = 1'b1;
    #1;
    // First edge after release must sample this op
    begin
      exp_t e;
      in_valid = 1'b1;
      a = 4'b1100;
      b = 4'b0101;
      sel = 3'b001;
      e.out = 4'b0111;
      e.c   = 1'b0;
      q.push_back(e);
    end

    // Randomised traffic with random idle gaps
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0)
        idle();
      else
        issue_model(int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)),
                    int'($urandom_range(0, 7)));
    end
    idle();

    // Drain the scoreboard with a bounded wait
    waited = 0;
    while (q.size() != 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    repeat (2) @(posedge clk);
    check("scoreboard_drained", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_alu_4
`default_nettype wire
